// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder
// PHY-side MDIO management responder for Clause 22 frames, with Clause 45
// MMD indirect access through registers 13/14. MDC and MDIO are sampled in
// the system clock domain; all MDIO drive changes are registered.

module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR  = 5'd0,
  parameter int          PRE_MIN   = 32,
  parameter logic [15:0] REG0_INIT = 16'h1140,
  parameter logic [15:0] REG9_INIT = 16'h0300
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic [15:0] phy_status,
  output logic [15:0] reg9_out,
  output logic [15:0] mmd_ctl_skew,
  output logic [15:0] mmd_rxd_skew,
  output logic [15:0] mmd_txd_skew,
  output logic [15:0] mmd_clk_skew,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr
);

  localparam int               PRE_W   = $clog2(PRE_MIN + 1);
  localparam logic [PRE_W-1:0] PRE_SAT = PRE_W'(PRE_MIN);

  // Register numbers with special behaviour.
  localparam logic [4:0] REG_MMD_CTL  = 5'd13;
  localparam logic [4:0] REG_MMD_DATA = 5'd14;
  localparam logic [4:0] REG_STATUS   = 5'd31;

  // Only this MMD device is backed by storage.
  localparam logic [4:0] MMD_DEV      = 5'd2;

  typedef enum logic [2:0] {
    S_PREAMBLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA1,
    S_TA2,
    S_DATA
  } state_e;

  // Synchroniser and edge-detect flops.
  logic mdc_meta_q, mdc_sync_q, mdc_prev_q;
  logic mdio_meta_q, mdio_sync_q;

  // Frame parser state.
  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             op_first_q, op_first_d;
  logic             is_read_q, is_read_d;
  logic             selected_q, selected_d;
  logic [4:0]       regad_q, regad_d;
  logic [15:0]      shift_q, shift_d;

  // Pad and write-notification outputs.
  logic             mdio_out_q, mdio_out_d;
  logic             mdio_oe_q, mdio_oe_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [4:0]       wr_addr_q, wr_addr_d;

  // Clause 22 register file and MMD device 2 storage.
  logic [15:0]      regs_q [32];
  logic [15:0]      regs_d [32];
  logic [15:0]      mmd_q  [16];
  logic [15:0]      mmd_d  [16];
  logic [3:0]       ptr_q, ptr_d;

  // Combinational helpers.
  logic             mdc_rise;
  logic             mdio_bit;
  logic [4:0]       full5;
  logic [15:0]      wr_data;
  logic [15:0]      rd_word;
  logic [1:0]       mmd_func;
  logic             mmd_dev_ok;

  assign mdc_rise   = mdc_sync_q & ~mdc_prev_q;
  assign mdio_bit   = mdio_sync_q;
  assign full5      = {shift_q[3:0], mdio_bit};
  assign wr_data    = {shift_q[14:0], mdio_bit};
  assign mmd_func   = regs_q[REG_MMD_CTL][15:14];
  assign mmd_dev_ok = (regs_q[REG_MMD_CTL][4:0] == MMD_DEV);

  // Two-flop synchronisers for MDC and MDIO, plus the previous MDC level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mdc_meta_q  <= 1'b0;
      mdc_sync_q  <= 1'b0;
      mdc_prev_q  <= 1'b0;
      mdio_meta_q <= 1'b1;
      mdio_sync_q <= 1'b1;
    end else begin
      // NOTE: every sequential assignment uses <= so all flops update from
      // pre-edge values; blocking here would collapse the synchroniser chain.
      mdc_meta_q  <= mdc;
      mdc_sync_q  <= mdc_meta_q;
      mdc_prev_q  <= mdc_sync_q;
      mdio_meta_q <= mdio_in;
      mdio_sync_q <= mdio_meta_q;
    end
  end

  // Read word selected by the register address completing this edge.
  always_comb begin
    rd_word = '0;
    case (full5)
      REG_STATUS: rd_word = phy_status;
      REG_MMD_DATA: begin
        if (!mmd_dev_ok)             rd_word = '0;
        else if (mmd_func == 2'b00)  rd_word = {12'h000, ptr_q};
        else                         rd_word = mmd_q[ptr_q];
      end
      default: rd_word = regs_q[full5];
    endcase
  end

  // Frame FSM next state, MDIO drive and register-file updates.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    op_first_d  = op_first_q;
    is_read_d   = is_read_q;
    selected_d  = selected_q;
    regad_d     = regad_q;
    shift_d     = shift_q;
    mdio_out_d  = mdio_out_q;
    mdio_oe_d   = mdio_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;
    mmd_d       = mmd_q;
    ptr_d       = ptr_q;

    // Soft-reset bit is visible for one clock after a write, then clears.
    if (regs_q[0][15]) regs_d[0][15] = 1'b0;

    if (mdc_rise) begin
      case (state_q)
        S_PREAMBLE: begin
          if (mdio_bit) begin
            if (pre_cnt_q < PRE_SAT) pre_cnt_d = pre_cnt_q + 1'b1;
          end else begin
            if (pre_cnt_q >= PRE_SAT) state_d = S_ST;
            pre_cnt_d = '0;
          end
        end

        S_ST: begin
          bit_cnt_d = '0;
          pre_cnt_d = '0;
          state_d   = mdio_bit ? S_OP : S_PREAMBLE;
        end

        S_OP: begin
          if (bit_cnt_q == 4'd0) begin
            op_first_d = mdio_bit;
            bit_cnt_d  = 4'd1;
          end else if (op_first_q != mdio_bit) begin
            // 10 = read, 01 = write: the first bit tells them apart.
            is_read_d = op_first_q;
            bit_cnt_d = '0;
            state_d   = S_PHYAD;
          end else begin
            pre_cnt_d = '0;
            state_d   = S_PREAMBLE;
          end
        end

        S_PHYAD: begin
          shift_d = wr_data;
          if (bit_cnt_q == 4'd4) begin
            selected_d = (full5 == PHY_ADDR);
            bit_cnt_d  = '0;
            state_d    = S_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        S_REGAD: begin
          shift_d = wr_data;
          if (bit_cnt_q == 4'd4) begin
            regad_d   = full5;
            bit_cnt_d = '0;
            state_d   = S_TA1;
            if (selected_q && is_read_q) begin
              // Latch the read word and take the bus with a 0 for turnaround.
              shift_d    = rd_word;
              mdio_oe_d  = 1'b1;
              mdio_out_d = 1'b0;
              if (full5 == REG_MMD_DATA && mmd_dev_ok && mmd_func == 2'b10)
                ptr_d = ptr_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        S_TA1: begin
          state_d = S_TA2;
        end

        S_TA2: begin
          if (selected_q && is_read_q) begin
            mdio_out_d = shift_q[15];
            shift_d    = {shift_q[14:0], 1'b0};
          end
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end

        S_DATA: begin
          if (is_read_q) begin
            if (selected_q) begin
              if (bit_cnt_q == 4'd15) begin
                mdio_oe_d  = 1'b0;
                mdio_out_d = 1'b1;
              end else begin
                mdio_out_d = shift_q[15];
                shift_d    = {shift_q[14:0], 1'b0};
              end
            end
          end else begin
            shift_d = wr_data;
          end

          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            pre_cnt_d = '0;
            state_d   = S_PREAMBLE;
            if (selected_q && !is_read_q) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = regad_q;
              case (regad_q)
                REG_STATUS: begin
                  // Live status register: writes are acknowledged but dropped.
                end
                REG_MMD_CTL: regs_d[REG_MMD_CTL] = wr_data & 16'hC01F;
                REG_MMD_DATA: begin
                  if (mmd_dev_ok) begin
                    if (mmd_func == 2'b00) begin
                      ptr_d = wr_data[3:0];
                    end else begin
                      mmd_d[ptr_q] = wr_data;
                      if (mmd_func[1]) ptr_d = ptr_q + 1'b1;
                    end
                  end
                end
                default: regs_d[regad_q] = wr_data;
              endcase
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        default: begin
          pre_cnt_d = '0;
          state_d   = S_PREAMBLE;
        end
      endcase
    end
  end

  // Frame state, pad drive and write-notification registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_PREAMBLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      op_first_q  <= 1'b0;
      is_read_q   <= 1'b0;
      selected_q  <= 1'b0;
      regad_q     <= '0;
      shift_q     <= '0;
      mdio_out_q  <= 1'b1;
      mdio_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      op_first_q  <= op_first_d;
      is_read_q   <= is_read_d;
      selected_q  <= selected_d;
      regad_q     <= regad_d;
      shift_q     <= shift_d;
      mdio_out_q  <= mdio_out_d;
      mdio_oe_q   <= mdio_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  // Register file and MMD storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset rather than left uninitialised because
      // every register has a defined power-on value seen by the station.
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      regs_q[0] <= REG0_INIT;
      regs_q[9] <= REG9_INIT;
      for (int i = 0; i < 16; i++) mmd_q[i] <= '0;
      ptr_q <= '0;
    end else begin
      regs_q <= regs_d;
      mmd_q  <= mmd_d;
      ptr_q  <= ptr_d;
    end
  end

  assign mdio_out     = mdio_out_q;
  assign mdio_oe      = mdio_oe_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign reg9_out     = regs_q[9];
  assign mmd_ctl_skew = mmd_q[4];
  assign mmd_rxd_skew = mmd_q[5];
  assign mmd_txd_skew = mmd_q[6];
  assign mmd_clk_skew = mmd_q[8];

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- MDIO management responder (PHY side) for IEEE 802.3 Clause 22 frames, with Clause 45 MMD indirect access through registers 13/14.
- Deserialises MDC/MDIO from the station manager, serves reads from a local register file and applies writes to it.
- Exports the configured RGMII skew and gigabit-advertise values to the datapath.
- Used in-FPGA as the PHY model for bench and loopback builds, and as a stand-in target when the real PHY is bypassed.

Parameters:
PHY_ADDR, 5'd0, PHY address this block answers to
PRE_MIN, 32, consecutive preamble 1s required before a start is accepted
REG0_INIT, 16'h1140, reset value of register 0
REG9_INIT, 16'h0300, reset value of register 9

Ports:
clock  input  1  system clock; at least 8x MDC frequency
reset  input  1  asynchronous, active-high reset
mdc  input  1  management clock from the station manager, asynchronous to clock
mdio_in  input  1  MDIO pad input
mdio_out  output  1  MDIO drive value
mdio_oe  output  1  MDIO output enable; 0 = released
phy_status  input  16  live value returned for register 31 (bits 6:5 speed, bit 3 duplex)
reg9_out  output  16  register 9 (bit 9 = 1000BASE-T full-duplex advertise)
mmd_ctl_skew  output  16  MMD dev 2 addr 4 (RX_CTL/TX_CTL skew)
mmd_rxd_skew  output  16  MMD dev 2 addr 5
mmd_txd_skew  output  16  MMD dev 2 addr 6
mmd_clk_skew  output  16  MMD dev 2 addr 8 (RX_CLK[4:0], TX_CLK[9:5])
wr_strobe  output  1  one-clock pulse per committed write
wr_addr  output  5  Clause 22 register of the last committed write

Behaviour:
- Reset is asynchronous. During reset: mdio_oe=0, mdio_out=1, wr_strobe=0, wr_addr=0, reg0=REG0_INIT, reg9=REG9_INIT, all other registers 0, MMD store 0, FSM=PREAMBLE, preamble count 0.
- A reset mid-frame aborts the frame and releases MDIO immediately.
- Synchronisation: mdc and mdio_in each pass through a 2-flop synchroniser.
- Edge detection: an MDC rising edge is detected on synchronised 0->1. mdio is sampled on that same clock.
- Output timing: all mdio_out/mdio_oe changes occur 1 clock after the detected rising edge (at most 4 clocks after the pin edge).
- FSM (one transition or bit per detected MDC rising edge):
  - PREAMBLE: sampled 1 increments the count, saturating at PRE_MIN. Sampled 0 with count >= PRE_MIN -> ST. Sampled 0 with count < PRE_MIN clears the count and stays.
  - ST: 1 -> OP. 0 -> PREAMBLE with count cleared.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11 -> PREAMBLE with count cleared.
  - PHYAD: 5 bits, MSB first. Match against PHY_ADDR gives "selected".
  - REGAD: 5 bits, MSB first.
  - TA1: on entry for a selected read, latch the read word, set mdio_oe=1, mdio_out=0.
  - TA2: for a selected read, shift out D15.
  - DATA: 16 bits. Read drives D14..D0 on successive edges. Write shifts in the sampled bit.
  - End of DATA, on the 16th DATA edge: a read sets mdio_oe=0. A selected write commits (pulse wr_strobe, set wr_addr). Count clears -> PREAMBLE.
- Unselected frames are parsed to the end but never drive MDIO or commit.
- Register file: 32x16. Reads of reg 31 return phy_status; writes to reg 31 are ignored (wr_strobe still pulses).
- Reg 0 bit 15 (soft reset) is self-clearing: it is stored as written for 1 clock, then cleared. It does not reset this block.
- MMD indirect access:
  - Reg 13 stores {func[15:14], devad[4:0]}.
  - Write to reg 14 with func=00: sets the MMD address pointer for devad.
  - Write to reg 14 with func=01/10/11: writes MMD data at the pointer. func 10 and 11 post-increment the pointer (4-bit, wrap 15->0).
  - Read of reg 14 with func=00 returns the pointer. With func=01/10/11 it returns MMD data; func 10 post-increments, func 11 does not.
  - Only devad 2, addresses 0..15 are stored. Other devads read 0 and writes are dropped.
- The five config outputs are continuous views of their storage, updated 1 clock after commit.

Test Plan:
- Preamble 32x1, write reg 9 = 0x0200, then read reg 9 -> reg9_out=0x0200 after commit; read returns 0x0200; mdio_oe high from TA1 through D0, TA2 bit=0; one wr_strobe with wr_addr=9.
- Writes 0d=0002, 0e=0004, 0d=4002, 0e=0077, and the same sequence for 0x0008 with 0x03F0 -> mmd_ctl_skew=0x0077, mmd_clk_skew=0x03F0; others unchanged at 0.
- phy_status=0x0048, read reg 31 -> serial data 0x0048; then write 0xFFFF to reg 31 and read again -> still 0x0048.
- Frame with PHYAD=PHY_ADDR+1 (read), and a frame preceded by only 31 ones -> mdio_oe stays 0 throughout; no wr_strobe; register file unchanged.
- Write reg 0 = 0x9140 -> reg 0 reads back 0x1140.
- Assert reset during D7 of a read -> mdio_oe=0 asynchronously; reg9_out=0x0300; the next valid frame decodes normally.
